ctr_decryption_stream: RTL and testbench

Streaming AES-256-CTR decryption controller: accepts ciphertext one 128-bit block at a time and drives an external AES-256 block-encrypt core through a start/done handshake to produce keystream blocks E(key, iv+i). It XORs each keystream block with the matching ciphertext block and emits plaintext on a valid/ready output. It is the receive-side counterpart of `ctr_encryption` and sits between the ciphertext source and the plaintext consumer, sharing the AES core interface used by the encrypt path.

---
 rtl/ctr_decryption_stream.sv | 118 +++++++++++
 tb/tb_ctr_decryption_stream.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ctr_decryption_stream.sv
// AES-256-CTR receive-side controller: generates keystream through an
// external AES core and XORs it with streamed ciphertext blocks.
module ctr_decryption_stream #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [255:0]     key,
   input  logic [127:0]     iv,
   input  logic [CNT_W-1:0] num_blocks,
   input  logic [127:0]     ct_data,
   input  logic             ct_valid,
   output logic             ct_ready,
   output logic [127:0]     pt_data,
   output logic             pt_valid,
   input  logic             pt_ready,
   output logic             pt_last,
   output logic             aes_start,
   output logic [255:0]     aes_key,
   output logic [127:0]     aes_block,
   input  logic             aes_done,
   input  logic [127:0]     aes_out,
   output logic             busy,
   output logic             done
);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] GEN_REQ  = 3'd1;
   localparam logic [2:0] GEN_WAIT = 3'd2;
   localparam logic [2:0] WAIT_CT  = 3'd3;
   localparam logic [2:0] OUT      = 3'd4;

   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [2:0]       state;
   logic [255:0]     key_q;
   logic [127:0]     ctr;
   logic [127:0]     ks_reg;
   logic [127:0]     pt_q;
   logic [CNT_W-1:0] nb_q;
   logic [CNT_W-1:0] blk_idx;
   logic [CNT_W-1:0] last_idx;
   logic             last_q;
   logic             done_q;

   assign last_idx  = nb_q - ONE;

   assign ct_ready  = (state == WAIT_CT);
   assign pt_valid  = (state == OUT);
   assign pt_last   = last_q & (state == OUT);
   assign pt_data   = pt_q;
   assign aes_start = (state == GEN_REQ);
   assign aes_key   = key_q;
   assign aes_block = ctr;
   assign busy      = (state != IDLE);
   assign done      = done_q;

   // Message sequencing: keystream request, ciphertext merge, plaintext hand-off
   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= IDLE;
         key_q   <= '0;
         ctr     <= '0;
         ks_reg  <= '0;
         pt_q    <= '0;
         nb_q    <= '0;
         blk_idx <= '0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  key_q   <= key;
                  ctr     <= iv;
                  nb_q    <= num_blocks;
                  blk_idx <= '0;
                  if (num_blocks == '0)
                     done_q <= 1'b1;
                  else
                     state <= GEN_REQ;
               end
            end
            GEN_REQ: state <= GEN_WAIT;
            GEN_WAIT: begin
               if (aes_done) begin
                  ks_reg <= aes_out;
                  state  <= WAIT_CT;
               end
            end
            WAIT_CT: begin
               if (ct_valid) begin
                  pt_q   <= ct_data ^ ks_reg;
                  last_q <= (blk_idx == last_idx);
                  state  <= OUT;
               end
            end
            OUT: begin
               if (pt_ready) begin
                  ctr     <= ctr + 128'd1;
                  blk_idx <= blk_idx + ONE;
                  last_q  <= 1'b0;
                  if (last_q) begin
                     done_q <= 1'b1;
                     state  <= IDLE;
                  end else begin
                     state <= GEN_REQ;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ctr_decryption_stream.sv
// Directed scoreboard bench for ctr_decryption_stream with an AES core stub
// (identity or keyed mixing function) of fixed latency.
module tb_ctr_decryption_stream;

   localparam int CNT_W = 4;
   localparam int LAT   = 3;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             start = 1'b0;
   logic [255:0]     key = '0;
   logic [127:0]     iv = '0;
   logic [CNT_W-1:0] num_blocks = '0;
   logic [127:0]     ct_data = '0;
   logic             ct_valid = 1'b0;
   logic             ct_ready;
   logic [127:0]     pt_data;
   logic             pt_valid;
   logic             pt_ready = 1'b0;
   logic             pt_last;
   logic             aes_start;
   logic [255:0]     aes_key;
   logic [127:0]     aes_block;
   logic             aes_done = 1'b0;
   logic [127:0]     aes_out = '0;
   logic             busy;
   logic             done;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;
   int n_starts = 0;
   int stub_cnt = 0;
   logic [127:0] stub_blk = '0;
   logic [255:0] stub_key = '0;
   bit keyed = 1'b0;
   logic [127:0] last_pt_obs = '0;

   logic [127:0] q_blk[$];
   logic [127:0] q_pt[$];
   logic         q_last[$];

   ctr_decryption_stream #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .start(start), .key(key), .iv(iv),
      .num_blocks(num_blocks), .ct_data(ct_data), .ct_valid(ct_valid),
      .ct_ready(ct_ready), .pt_data(pt_data), .pt_valid(pt_valid),
      .pt_ready(pt_ready), .pt_last(pt_last), .aes_start(aes_start),
      .aes_key(aes_key), .aes_block(aes_block), .aes_done(aes_done),
      .aes_out(aes_out), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   function automatic logic [127:0] ks_fn(input logic [127:0] b,
                                          input logic [255:0] k,
                                          input bit kd);
      if (!kd) return b;
      return {b[62:0], b[127:63]} ^ k[255:128] ^ {k[63:0], k[127:64]};
   endfunction

   task automatic chk(input string tag, input logic [255:0] obs,
                      input logic [255:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // AES core stub: answers each request LAT+1 edges later; checks request order
   always @(posedge clk) begin
      aes_done <= 1'b0;
      if (stub_cnt == 1) begin
         aes_done <= 1'b1;
         aes_out  <= ks_fn(stub_blk, stub_key, keyed);
      end
      if (stub_cnt > 0) stub_cnt <= stub_cnt - 1;
      if (aes_start) begin
         n_starts++;
         stub_cnt <= LAT;
         stub_blk <= aes_block;
         stub_key <= aes_key;
         if (q_blk.size() == 0) chk("aes_block_unexpected", {128'd0, aes_block}, 256'd0);
         else chk("aes_block", {128'd0, aes_block}, {128'd0, q_blk.pop_front()});
      end
   end

   task automatic run_msg(input logic [255:0] k, input logic [127:0] iv0,
                          input int n, input int ct_dly, input int pt_stall,
                          input bit busy_start, input int abort_at,
                          input bit use_ct0, input logic [127:0] ct0);
      logic [127:0] cts[$];
      logic [127:0] c, ks, ct, ptv, held;
      int w;
      q_blk.delete(); q_pt.delete(); q_last.delete();
      for (int i = 0; i < n; i++) begin
         c  = iv0 + 128'(i);
         ks = ks_fn(c, k, keyed);
         ct = {$urandom, $urandom, $urandom, $urandom};
         if (i == 0 && use_ct0) ct = ct0;
         q_blk.push_back(c);
         q_pt.push_back(ct ^ ks);
         q_last.push_back(i == n - 1);
         cts.push_back(ct);
      end
      n_starts = 0;
      key = k; iv = iv0; num_blocks = CNT_W'(n); start = 1'b1;
      tick();
      start = 1'b0;
      if (n == 0) begin
         chk("zero_done", {255'd0, done}, 256'd1);
         chk("zero_busy", {255'd0, busy}, 256'd0);
         tick();
         chk("zero_done_fall", {255'd0, done}, 256'd0);
         chk("zero_no_aes_start", 256'(n_starts), 256'd0);
         return;
      end
      chk("start_aes_start", {255'd0, aes_start}, 256'd1);
      chk("start_busy", {255'd0, busy}, 256'd1);
      if (busy_start) begin
         key = ~k; iv = ~iv0; num_blocks = CNT_W'(n + 3); start = 1'b1;
         tick();
         start = 1'b0; key = k; iv = iv0;
         chk("busy_start_key", aes_key, k);
         chk("busy_start_aes_start", {255'd0, aes_start}, 256'd0);
      end
      for (int i = 0; i < n; i++) begin
         if (i == abort_at) begin
            tick();
            rst = 1'b0;
            tick();
            rst = 1'b1;
            chk("rst_ct_ready", {255'd0, ct_ready}, 256'd0);
            chk("rst_pt_valid", {255'd0, pt_valid}, 256'd0);
            chk("rst_pt_last", {255'd0, pt_last}, 256'd0);
            chk("rst_aes_start", {255'd0, aes_start}, 256'd0);
            chk("rst_busy", {255'd0, busy}, 256'd0);
            chk("rst_done", {255'd0, done}, 256'd0);
            chk("rst_pt_data", {128'd0, pt_data}, 256'd0);
            chk("rst_aes_block", {128'd0, aes_block}, 256'd0);
            chk("rst_aes_key", aes_key, 256'd0);
            w = 0;
            repeat (10) begin
               tick();
               if (done || busy) w++;
            end
            chk("rst_stray_ignored", 256'(w), 256'd0);
            chk("rst_start_count", 256'(n_starts), 256'(abort_at + 1));
            q_blk.delete(); q_pt.delete(); q_last.delete();
            return;
         end
         w = 0;
         while (!ct_ready && w < 100) begin
            tick();
            w++;
         end
         chk("ct_ready_wait", {255'd0, ct_ready}, 256'd1);
         chk("ct_ready_no_pt_valid", {255'd0, pt_valid}, 256'd0);
         repeat (ct_dly) tick();
         chk("ct_ready_held", {255'd0, ct_ready}, 256'd1);
         ct_data = cts[i]; ct_valid = 1'b1;
         tick();
         ct_valid = 1'b0; ct_data = '0;
         chk("pt_valid_rise", {255'd0, pt_valid}, 256'd1);
         chk("out_ct_ready_low", {255'd0, ct_ready}, 256'd0);
         held = pt_data;
         for (int s = 0; s < pt_stall; s++) begin
            tick();
            chk("stall_pt_data", {128'd0, pt_data}, {128'd0, held});
            chk("stall_pt_valid", {255'd0, pt_valid}, 256'd1);
         end
         ptv = q_pt.pop_front();
         chk("pt_data", {128'd0, pt_data}, {128'd0, ptv});
         chk("pt_last", {255'd0, pt_last}, {255'd0, q_last.pop_front()});
         last_pt_obs = pt_data;
         pt_ready = 1'b1; ct_valid = 1'b1;
         tick();
         pt_ready = 1'b0; ct_valid = 1'b0;
         if (i == n - 1) begin
            chk("last_done", {255'd0, done}, 256'd1);
            chk("last_busy", {255'd0, busy}, 256'd0);
            tick();
            chk("done_fall", {255'd0, done}, 256'd0);
         end else begin
            chk("next_aes_start", {255'd0, aes_start}, 256'd1);
            chk("mid_done", {255'd0, done}, 256'd0);
         end
      end
      chk("aes_start_count", 256'(n_starts), 256'(n));
      chk("blk_queue_empty", 256'(q_blk.size()), 256'd0);
   endtask

   initial begin
      rst = 1'b0;
      tick();
      tick();
      chk("reset_busy", {255'd0, busy}, 256'd0);
      chk("reset_ct_ready", {255'd0, ct_ready}, 256'd0);
      chk("reset_pt_valid", {255'd0, pt_valid}, 256'd0);
      chk("reset_aes_start", {255'd0, aes_start}, 256'd0);
      chk("reset_pt_data", {128'd0, pt_data}, 256'd0);
      rst = 1'b1;
      tick();

      keyed = 1'b0;
      run_msg('0, 128'h00112233445566778899aabbccddeeff, 1, 0, 0, 0, -1,
              1, 128'h0123456789abcdef0123456789abcdef);
      chk("single_pt_const", {128'd0, last_pt_obs},
          {128'd0, 128'h01326754cdfeab9889baefdc45762310});

      run_msg('0, {128{1'b1}}, 2, 0, 0, 0, -1, 0, '0);

      keyed = 1'b1;
      run_msg({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
               $urandom, $urandom}, 128'h5, 3, 4, 5, 0, -1, 0, '0);

      run_msg(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
              128'h00112233445566778899aabbccddeeff, 8, 0, 0, 0, -1, 0, '0);

      run_msg({8{32'hdeadbeef}}, 128'h100, 3, 0, 0, 0, 1, 0, '0);
      run_msg({8{32'h13572468}}, 128'hfedcba9876543210fedcba9876543210,
              2, 1, 1, 0, -1, 0, '0);

      run_msg({8{32'h0badf00d}}, 128'h77, 0, 0, 0, 0, -1, 0, '0);

      run_msg({8{32'hcafef00d}}, 128'hfffffffffffffffffffffffffffffffe,
              2, 0, 2, 1, -1, 0, '0);

      run_msg({8{32'h2468ace0}}, 128'h1234, 15, 0, 0, 0, -1, 0, '0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
